// File: rtl/full_subtractor_reg.sv
`default_nettype none
// ============================================================================
// Module   : full_subtractor_reg
// Brief    : Ripple-borrow WIDTH-bit subtractor (d = a - b - bin) with both
//            a combinational result and a 1-cycle registered result.
// Revision : 1.0 - initial release
// ============================================================================
module full_subtractor_reg #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic [WIDTH-1:0] d_comb,
    output logic             bout_comb,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             out_valid
);

    logic [WIDTH:0]   w_br;
    logic [WIDTH-1:0] w_diff;

    logic [WIDTH-1:0] r_d;
    logic             r_bout;
    logic             r_out_valid;

    assign w_br[0] = bin;

    // One full-subtractor cell per bit; borrow ripples from LSB to MSB.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
            assign w_diff[gi]  = a[gi] ^ b[gi] ^ w_br[gi];
            assign w_br[gi+1]  = (~a[gi] & b[gi]) | (~(a[gi] ^ b[gi]) & w_br[gi]);
        end
    endgenerate

    assign d_comb    = w_diff;
    assign bout_comb = w_br[WIDTH];

    // Reset has priority; without in_valid the result holds but the
    // qualifier drops so downstream sees each result exactly once.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_d         <= '0;
            r_bout      <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (in_valid) begin
            r_d         <= w_diff;
            r_bout      <= w_br[WIDTH];
            r_out_valid <= 1'b1;
        end else begin
            r_out_valid <= 1'b0;
        end
    end

    assign d         = r_d;
    assign bout      = r_bout;
    assign out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_full_subtractor_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_full_subtractor_reg
// Brief    : Scoreboard bench for full_subtractor_reg at WIDTH = 1, 8 and 32.
// Revision : 1.0 - initial release
// ============================================================================
module tb_full_subtractor_reg;

    logic clk;
    logic rst_n;
    logic in_valid;

    logic [0:0]  a1, b1, dc1, d1;
    logic        c1, bc1, bo1, ov1;
    logic [7:0]  a8, b8, dc8, d8;
    logic        c8, bc8, bo8, ov8;
    logic [31:0] a32, b32, dc32, d32;
    logic        c32, bc32, bo32, ov32;

    full_subtractor_reg #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .a(a1), .b(b1), .bin(c1),
        .d_comb(dc1), .bout_comb(bc1), .d(d1), .bout(bo1), .out_valid(ov1)
    );
    full_subtractor_reg #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .a(a8), .b(b8), .bin(c8),
        .d_comb(dc8), .bout_comb(bc8), .d(d8), .bout(bo8), .out_valid(ov8)
    );
    full_subtractor_reg #(.WIDTH(32)) u_w32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .a(a32), .b(b32), .bin(c32),
        .d_comb(dc32), .bout_comb(bc32), .d(d32), .bout(bo32), .out_valid(ov32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        v;
        logic [63:0] d1, d8, d32;
        logic        b1, b8, b32;
    } exp_t;

    exp_t q[$];

    // Staged stimulus for the next cycle.
    logic        s_rst_n, s_v;
    logic [63:0] s_a1, s_b1, s_a8, s_b8, s_a32, s_b32;
    logic        s_c1, s_c8, s_c32;

    // Reference state of the output register.
    logic [63:0] m_d1, m_d8, m_d32;
    logic        m_b1, m_b8, m_b32;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Plain unsigned arithmetic: difference modulo 2^w, borrow iff a < b + bin.
    function automatic logic [64:0] ref_sub(input int w, input logic [63:0] a,
                                            input logic [63:0] b, input logic c);
        logic [64:0] mask;
        logic [64:0] diff;
        logic        brw;
        mask = (65'd1 << w) - 65'd1;
        diff = ({1'b0, a} - {1'b0, b} - {64'd0, c}) & mask;
        brw  = ({1'b0, a} < ({1'b0, b} + {64'd0, c}));
        return {brw, diff[63:0]};
    endfunction

    task automatic step();
        logic [64:0] r1, r8, r32;
        exp_t e;
        @(negedge clk);
        #1;
        rst_n = s_rst_n; in_valid = s_v;
        a1  = s_a1[0:0];  b1  = s_b1[0:0];  c1  = s_c1;
        a8  = s_a8[7:0];  b8  = s_b8[7:0];  c8  = s_c8;
        a32 = s_a32[31:0]; b32 = s_b32[31:0]; c32 = s_c32;
        #1;
        r1  = ref_sub(1,  s_a1  & 64'h1,        s_b1  & 64'h1,        s_c1);
        r8  = ref_sub(8,  s_a8  & 64'hFF,       s_b8  & 64'hFF,       s_c8);
        r32 = ref_sub(32, s_a32 & 64'hFFFFFFFF, s_b32 & 64'hFFFFFFFF, s_c32);
        chk("w1_d_comb",    {63'd0, dc1},  r1[63:0]);
        chk("w1_bout_comb", {63'd0, bc1},  {63'd0, r1[64]});
        chk("w8_d_comb",    {56'd0, dc8},  r8[63:0]);
        chk("w8_bout_comb", {63'd0, bc8},  {63'd0, r8[64]});
        chk("w32_d_comb",   {32'd0, dc32}, r32[63:0]);
        chk("w32_bout_comb",{63'd0, bc32}, {63'd0, r32[64]});
        if (!s_rst_n) begin
            m_d1 = '0; m_d8 = '0; m_d32 = '0;
            m_b1 = 1'b0; m_b8 = 1'b0; m_b32 = 1'b0;
            e.v = 1'b0;
        end else if (s_v) begin
            m_d1 = r1[63:0]; m_d8 = r8[63:0]; m_d32 = r32[63:0];
            m_b1 = r1[64];   m_b8 = r8[64];   m_b32 = r32[64];
            e.v = 1'b1;
        end else begin
            e.v = 1'b0;
        end
        e.d1 = m_d1; e.d8 = m_d8; e.d32 = m_d32;
        e.b1 = m_b1; e.b8 = m_b8; e.b32 = m_b32;
        q.push_back(e);
    endtask

    // Monitor: one expected entry per clock edge that stimulus covered.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("w1_out_valid",  {63'd0, ov1},  {63'd0, e.v});
            chk("w8_out_valid",  {63'd0, ov8},  {63'd0, e.v});
            chk("w32_out_valid", {63'd0, ov32}, {63'd0, e.v});
            chk("w1_d",    {63'd0, d1},  e.d1);
            chk("w1_bout", {63'd0, bo1}, {63'd0, e.b1});
            chk("w8_d",    {56'd0, d8},  e.d8);
            chk("w8_bout", {63'd0, bo8}, {63'd0, e.b8});
            chk("w32_d",   {32'd0, d32}, e.d32);
            chk("w32_bout",{63'd0, bo32},{63'd0, e.b32});
        end
    end

    task automatic set_w8(input logic [7:0] a, input logic [7:0] b, input logic c);
        s_a8 = {56'd0, a}; s_b8 = {56'd0, b}; s_c8 = c;
    endtask

    logic [1:0] tbl1 [8];
    logic [8:0] tbl8 [5];
    logic [2:0] vec;

    initial begin
        tbl1 = '{2'b00, 2'b11, 2'b11, 2'b01, 2'b10, 2'b00, 2'b00, 2'b11};
        tbl8 = '{{1'b0, 8'h02}, {1'b1, 8'hFF}, {1'b1, 8'hFF}, {1'b1, 8'hFF}, {1'b0, 8'h00}};
        rst_n = 1'b0; in_valid = 1'b0;
        a1 = '0; b1 = '0; c1 = 1'b0; a8 = '0; b8 = '0; c8 = 1'b0;
        a32 = '0; b32 = '0; c32 = 1'b0;
        s_a1 = '0; s_b1 = '0; s_c1 = 1'b0; s_a8 = '0; s_b8 = '0; s_c8 = 1'b0;
        s_a32 = '0; s_b32 = '0; s_c32 = 1'b0;
        m_d1 = '0; m_d8 = '0; m_d32 = '0; m_b1 = 1'b0; m_b8 = 1'b0; m_b32 = 1'b0;

        // Reset with in_valid asserted: registered outputs must be zero.
        s_rst_n = 1'b0; s_v = 1'b1;
        step(); step();

        // Release with in_valid low: out_valid must stay low.
        s_rst_n = 1'b1; s_v = 1'b0;
        step();

        // WIDTH=1 truth table, one vector per cycle.
        s_v = 1'b1;
        for (int i = 0; i < 8; i++) begin
            vec = i[2:0];
            s_a1 = {63'd0, vec[2]}; s_b1 = {63'd0, vec[1]}; s_c1 = vec[0];
            step();
            chk("w1_table", {62'd0, dc1, bc1}, {62'd0, tbl1[i]});
        end

        // WIDTH=8 directed boundary vectors.
        for (int i = 0; i < 5; i++) begin
            case (i)
                0: set_w8(8'h05, 8'h03, 1'b0);
                1: set_w8(8'h00, 8'h01, 1'b0);
                2: set_w8(8'h00, 8'h00, 1'b1);
                3: set_w8(8'hFF, 8'hFF, 1'b1);
                default: set_w8(8'h80, 8'h7F, 1'b1);
            endcase
            step();
            chk("w8_directed", {55'd0, bc8, dc8}, {55'd0, tbl8[i]});
        end

        // Capture 0x10 - 0x01, then hold for three cycles with new operands.
        set_w8(8'h10, 8'h01, 1'b0);
        step();
        s_v = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_w8(8'($urandom), 8'($urandom), 1'($urandom));
            s_a32 = {32'd0, $urandom}; s_b32 = {32'd0, $urandom};
            step();
        end

        // Mid-stream reset while in_valid is high drops the operand.
        s_rst_n = 1'b0; s_v = 1'b1;
        set_w8(8'h33, 8'h11, 1'b0);
        step();
        s_rst_n = 1'b1;

        // Randomized traffic with occasional idle cycles and resets.
        for (int i = 0; i < 1000; i++) begin
            s_rst_n = ($urandom_range(0, 49) != 0);
            s_v     = ($urandom_range(0, 3) != 0);
            s_a1  = {63'd0, 1'($urandom)}; s_b1 = {63'd0, 1'($urandom)}; s_c1 = 1'($urandom);
            s_a8  = {56'd0, 8'($urandom)}; s_b8 = {56'd0, 8'($urandom)}; s_c8 = 1'($urandom);
            s_a32 = {32'd0, $urandom};     s_b32 = {32'd0, $urandom};    s_c32 = 1'($urandom);
            if (i % 97 == 0) begin
                s_a32 = 64'hFFFFFFFF; s_b32 = 64'hFFFFFFFF;
            end
            step();
        end

        s_rst_n = 1'b1; s_v = 1'b0;
        step(); step();
        @(posedge clk);
        #3;
        chk("scoreboard_drained", 64'(q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
